// File: rtl/bp_be_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_be_pkg
// Description : Shared back-end helpers; FE queue pointer width (wrap bit + index)
// Revision    : 1.0
// ============================================================================

`define BP_BE_FE_QUEUE_PTR_WIDTH(els_p) (bp_be_pkg::fe_queue_ptr_width_f(els_p))

package bp_be_pkg;

    function automatic int fe_queue_ptr_width_f(input int els);
        return $clog2(els) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bsg_mem_1r1w.sv
`default_nettype none
// ============================================================================
// Module      : bsg_mem_1r1w
// Description : els_p x width_p storage, one synchronous write, one async read
// Revision    : 1.0
// ============================================================================
module bsg_mem_1r1w #(
    parameter int els_p   = 8,
    parameter int width_p = 64,
    localparam int ADDR_W = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic               clk_i,
    input  logic               w_v_i,
    input  logic [ADDR_W-1:0]  w_addr_i,
    input  logic [width_p-1:0] w_data_i,
    input  logic [ADDR_W-1:0]  r_addr_i,
    output logic [width_p-1:0] r_data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem[r_addr_i];

endmodule
`default_nettype wire

// File: rtl/bp_be_fe_queue_rollback_buf.sv
`default_nettype none
// ============================================================================
// Module      : bp_be_fe_queue_rollback_buf
// Description : Speculative FE-queue FIFO with write / speculative-read / commit
//               pointers supporting replay (roll), multi-entry commit and clear
// Revision    : 1.0
// ============================================================================
module bp_be_fe_queue_rollback_buf #(
    parameter int els_p     = 8,
    parameter int width_p   = 64,
    parameter int deq_els_p = 2,
    localparam int PTR_W    = `BP_BE_FE_QUEUE_PTR_WIDTH(els_p),
    localparam int LG_ELS   = PTR_W - 1,
    localparam int CNT_W    = $clog2(els_p + 1),
    localparam int DEQ_W    = $clog2(deq_els_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    input  logic               deq_i,
    input  logic [DEQ_W-1:0]   deq_cnt_i,
    input  logic               roll_i,
    input  logic               clr_i,
    output logic               empty_o,
    output logic               full_o,
    output logic [CNT_W-1:0]   count_o
);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] cptr_q, cptr_d;
    logic             ready_q, ready_d;

    logic [PTR_W-1:0] occupancy;
    logic [PTR_W-1:0] unread;
    logic [PTR_W-1:0] inflight;
    logic [PTR_W-1:0] occupancy_next;
    logic             enq;
    logic             mem_w_v;

    assign occupancy = wptr_q - cptr_q;
    assign unread    = wptr_q - rptr_q;
    assign inflight  = rptr_q - cptr_q;

    assign enq     = v_i & ready_q;
    // A handshake accepted in a clear cycle is dropped, never stored
    assign mem_w_v = enq & ~clr_i;

    always_comb begin
        wptr_d = wptr_q;
        cptr_d = cptr_q;
        rptr_d = rptr_q;

        if (clr_i) begin
            cptr_d = wptr_q;
            rptr_d = wptr_q;
        end else begin
            if (enq) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (deq_i) begin
                cptr_d = cptr_q + PTR_W'(deq_cnt_i);
            end
            // Rewind lands on the post-commit pointer so same-cycle deq is honoured
            if (roll_i) begin
                rptr_d = cptr_d;
            end else if (yumi_i) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
        end

        occupancy_next = wptr_d - cptr_d;
        ready_d        = (occupancy_next != PTR_W'(els_p));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cptr_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cptr_q  <= cptr_d;
            ready_q <= ready_d;
        end
    end

    bsg_mem_1r1w #(
        .els_p   (els_p),
        .width_p (width_p)
    ) u_mem (
        .clk_i    (clk_i),
        .w_v_i    (mem_w_v),
        .w_addr_i (wptr_q[LG_ELS-1:0]),
        .w_data_i (data_i),
        .r_addr_i (rptr_q[LG_ELS-1:0]),
        .r_data_o (data_o)
    );

    assign ready_o = ready_q;
    assign v_o     = (unread != '0);
    assign full_o  = (occupancy == PTR_W'(els_p));
    assign empty_o = (occupancy == '0);
    assign count_o = CNT_W'(occupancy);

    a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        deq_i |-> (PTR_W'(deq_cnt_i) <= inflight));

endmodule
`default_nettype wire

// File: tb/tb_bp_be_fe_queue_rollback_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_be_fe_queue_rollback_buf
// Description : Directed + randomized bench against a queue-based reference
// Revision    : 1.0
// ============================================================================
module tb_bp_be_fe_queue_rollback_buf;

    localparam int ELS = 8;
    localparam int W   = 64;

    logic          clk;
    logic          reset_n;
    logic [W-1:0]  data_i;
    logic          v_i;
    logic          ready_o;
    logic [W-1:0]  data_o;
    logic          v_o;
    logic          yumi_i;
    logic          deq_i;
    logic [1:0]    deq_cnt_i;
    logic          roll_i;
    logic          clr_i;
    logic          empty_o;
    logic          full_o;
    logic [3:0]    count_o;

    bp_be_fe_queue_rollback_buf #(.els_p(ELS), .width_p(W), .deq_els_p(2)) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .data_i    (data_i),
        .v_i       (v_i),
        .ready_o   (ready_o),
        .data_o    (data_o),
        .v_o       (v_o),
        .yumi_i    (yumi_i),
        .deq_i     (deq_i),
        .deq_cnt_i (deq_cnt_i),
        .roll_i    (roll_i),
        .clr_i     (clr_i),
        .empty_o   (empty_o),
        .full_o    (full_o),
        .count_o   (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: resident entries in order, how many are read, registered ready
    logic [W-1:0] q [$];
    int           nread;
    logic         rdy_m;
    int           n_cmp;
    int           n_mis;
    logic         chk_en;
    logic         enq_m;

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            nread = 0;
            rdy_m = 1'b0;
        end else begin
            enq_m = v_i && rdy_m;
            if (clr_i) begin
                q.delete();
                nread = 0;
            end else begin
                if (deq_i) begin
                    for (int k = 0; k < int'(deq_cnt_i); k++) void'(q.pop_front());
                    nread -= int'(deq_cnt_i);
                end
                if (roll_i) nread = 0;
                else if (yumi_i) nread++;
                if (enq_m) q.push_back(data_i);
            end
            rdy_m = (q.size() != ELS);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("v_o",     {63'd0, v_o},     {63'd0, (nread < q.size())});
            cmp("count_o", {60'd0, count_o}, 64'(q.size()));
            cmp("empty_o", {63'd0, empty_o}, {63'd0, (q.size() == 0)});
            cmp("full_o",  {63'd0, full_o},  {63'd0, (q.size() == ELS)});
            cmp("ready_o", {63'd0, ready_o}, {63'd0, rdy_m});
            if (nread < q.size()) cmp("data_o", data_o, q[nread]);
        end
    end

    task automatic idle();
        v_i = 0; yumi_i = 0; deq_i = 0; deq_cnt_i = 0; roll_i = 0; clr_i = 0;
    endtask

    int k_rx;
    int sent;
    int cyc;

    initial begin
        n_cmp = 0; n_mis = 0; chk_en = 0;
        reset_n = 0; data_i = '0; idle();
        repeat (2) @(negedge clk);
        cmp("rst_ready", {63'd0, ready_o}, 64'd0);
        cmp("rst_v",     {63'd0, v_o},     64'd0);
        cmp("rst_empty", {63'd0, empty_o}, 64'd1);
        cmp("rst_full",  {63'd0, full_o},  64'd0);
        cmp("rst_count", {60'd0, count_o}, 64'd0);
        reset_n = 1;
        chk_en  = 1;
        @(negedge clk);
        cmp("ready_after_release", {63'd0, ready_o}, 64'd1);

        for (int i = 0; i < 8; i++) begin
            v_i = 1; data_i = 64'h10 + 64'(i);
            @(negedge clk);
        end
        idle();
        cmp("fill_full",  {63'd0, full_o},  64'd1);
        cmp("fill_ready", {63'd0, ready_o}, 64'd0);
        cmp("fill_count", {60'd0, count_o}, 64'd8);
        cmp("fill_data",  data_o, 64'h10);

        for (int i = 0; i < 5; i++) begin
            cmp("yumi_seq", data_o, 64'h10 + 64'(i));
            yumi_i = 1;
            @(negedge clk);
        end
        idle();
        deq_i = 1; deq_cnt_i = 2;
        @(negedge clk);
        cmp("deq_ready", {63'd0, ready_o}, 64'd1);
        @(negedge clk);
        idle();
        cmp("deq_count", {60'd0, count_o}, 64'd4);

        for (int i = 0; i < 2; i++) begin
            yumi_i = 1;
            @(negedge clk);
        end
        idle();
        roll_i = 1; yumi_i = 1;
        @(negedge clk);
        idle();
        cmp("roll_data",  data_o, 64'h14);
        cmp("roll_count", {60'd0, count_o}, 64'd4);

        v_i = 1; data_i = 64'h18;
        @(negedge clk);
        cmp("pre_clr_count", {60'd0, count_o}, 64'd5);
        clr_i = 1; v_i = 1; data_i = 64'hAA;
        @(negedge clk);
        idle();
        cmp("clr_empty", {63'd0, empty_o}, 64'd1);
        cmp("clr_v",     {63'd0, v_o},     64'd0);
        cmp("clr_count", {60'd0, count_o}, 64'd0);
        v_i = 1; data_i = 64'h20;
        @(negedge clk);
        idle();
        cmp("post_clr_data", data_o, 64'h20);
        yumi_i = 1;
        @(negedge clk);
        idle();
        deq_i = 1; deq_cnt_i = 1;
        @(negedge clk);
        idle();

        k_rx = 0; sent = 0; cyc = 0;
        while (k_rx < 40 && cyc < 100) begin
            idle();
            if (sent < 40 && rdy_m) begin
                v_i = 1; data_i = 64'h30 + 64'(sent); sent++;
            end
            if (nread < q.size()) begin
                cmp("wrap_order", data_o, 64'h30 + 64'(k_rx));
                yumi_i = 1; k_rx++;
            end
            if (nread >= 1) begin
                deq_i = 1; deq_cnt_i = 1;
            end
            cmp("wrap_not_full", {63'd0, full_o}, 64'd0);
            @(negedge clk);
            cyc++;
        end
        if (k_rx < 40) begin
            n_cmp++; n_mis++;
            $display("FAIL wrap_timeout: got %0d entries, expected 40", k_rx);
        end
        idle();
        while (nread > 0) begin
            deq_i = 1; deq_cnt_i = (nread >= 2) ? 2'd2 : 2'd1;
            @(negedge clk);
        end
        idle();

        for (int n = 0; n < 3000; n++) begin
            idle();
            v_i    = ($urandom_range(0, 3) != 0);
            data_i = {$urandom, $urandom};
            if (nread < q.size()) yumi_i = ($urandom_range(0, 2) != 0);
            deq_i     = ($urandom_range(0, 1) == 1);
            deq_cnt_i = 2'($urandom_range(0, (nread < 2) ? nread : 2));
            roll_i    = ($urandom_range(0, 15) == 0);
            clr_i     = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        idle();

        cyc = 0;
        while (q.size() < ELS && cyc < 50) begin
            v_i = rdy_m; data_i = {$urandom, $urandom};
            @(negedge clk);
            cyc++;
        end
        idle();
        cmp("pre_async_full", {63'd0, full_o}, 64'd1);
        #3;
        reset_n = 0;
        #1;
        cmp("async_v",     {63'd0, v_o},     64'd0);
        cmp("async_ready", {63'd0, ready_o}, 64'd0);
        cmp("async_count", {60'd0, count_o}, 64'd0);
        cmp("async_empty", {63'd0, empty_o}, 64'd1);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        cmp("async_release_ready", {63'd0, ready_o}, 64'd1);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
